// File: rtl/pixel_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fb_pkg
//  Description : Shared constants, types and helpers for the double-buffered
//                64x32 RGB pixel frame buffer.
//                - FB_* geometry constants and derived field widths
//                - rgb_t        : 3-bit {R,G,B} pixel colour
//                - fb_state_t   : control FSM states
//                - tp_color()   : column-based test pattern colour
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_fb_pkg;

    localparam int FB_COLS     = 64;
    localparam int FB_ROWS     = 32;
    localparam int FB_ROWPAIRS = 16;
    localparam int FB_ADDR_W   = 10;

    localparam int FB_COL_W = $clog2(FB_COLS);
    localparam int FB_ROW_W = $clog2(FB_ROWS);
    localparam int FB_RP_W  = $clog2(FB_ROWPAIRS);

    typedef logic [2:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } fb_state_t;

    // Priority matters: a column divisible by 16 is also divisible by 8/4/2.
    function automatic rgb_t tp_color(input logic [FB_COL_W-1:0] col);
        rgb_t c;
        if (col[3:0] == 4'd0)      c = 3'b100;
        else if (col[2:0] == 3'd0) c = 3'b010;
        else if (col[1:0] == 2'd0) c = 3'b001;
        else if (col[0] == 1'b0)   c = 3'b111;
        else                       c = 3'b000;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_half_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fb_half_ram
//  Description : 1024 x 3-bit RAM holding one half (16 rows) of one bank.
//                One write port, one synchronous read port. Contents are not
//                reset; only the read data register is.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                we/waddr/wdata - write port
//                re/raddr   - read request (data valid next cycle)
//                rdata      - registered read data, holds while re=0
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_half_ram
    import pixel_fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [FB_ADDR_W-1:0] waddr,
    input  rgb_t                 wdata,
    input  logic                 re,
    input  logic [FB_ADDR_W-1:0] raddr,
    output rgb_t                 rdata
);

    localparam int c_depth = 1 << FB_ADDR_W;

    rgb_t r_mem [c_depth];
    rgb_t r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_frame_buffer
//  Description : Double-buffered 64x32 x 3-bit RGB frame store feeding an LED
//                matrix scan driver. Pixel writes and clears go to the back
//                bank; reads come from the front bank and return the top and
//                bottom row of a row pair together. Banks swap only on the
//                scan driver's frame_done.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                wr_en/wr_x/wr_y/wr_rgb   - single pixel write (back bank)
//                clr_req                  - fill back bank with CLR_RGB
//                swap_req                 - swap banks at next frame_done
//                busy, swap_ack           - status / swap pulse
//                rd_en/rd_row/rd_col      - read request (1-cycle latency)
//                rd_rgb0, rd_rgb1         - top / bottom half colour
//                frame_done               - end-of-frame pulse from scanner
//                test_en                  - test pattern select
//  Config      : PIXEL_FB_TESTPAT_EN - when defined, test_en=1 replaces read
//                data with a column-based colour pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_buffer
    import pixel_fb_pkg::*;
#(
    parameter rgb_t CLR_RGB = 3'b000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [FB_COL_W-1:0] wr_x,
    input  logic [FB_ROW_W-1:0] wr_y,
    input  rgb_t                wr_rgb,
    input  logic                clr_req,
    input  logic                swap_req,
    output logic                busy,
    output logic                swap_ack,
    input  logic                rd_en,
    input  logic [FB_RP_W-1:0]  rd_row,
    input  logic [FB_COL_W-1:0] rd_col,
    output rgb_t                rd_rgb0,
    output rgb_t                rd_rgb1,
    input  logic                frame_done,
    input  logic                test_en
);

    fb_state_t              r_state;
    fb_state_t              w_state_nxt;
    logic [FB_ADDR_W-1:0]   r_clr_addr;
    logic                   r_front_sel;
    logic                   r_swap_ack;
    logic                   r_rd_bank;

    logic                   w_clr_we;
    logic                   w_px_we;
    logic                   w_swap_fire;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        w_px_we     = 1'b0;
        w_swap_fire = 1'b0;
        case (r_state)
            IDLE: begin
                w_px_we = wr_en;
                // A clear wins over a simultaneous swap; that swap is lost.
                if (clr_req) begin
                    w_state_nxt = CLEAR;
                end else if (swap_req) begin
                    w_state_nxt = SWAP_WAIT;
                end
            end
            CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == {FB_ADDR_W{1'b1}}) begin
                    w_state_nxt = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (frame_done) begin
                    w_swap_fire = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr  <= '0;
            r_front_sel <= 1'b0;
            r_swap_ack  <= 1'b0;
            r_rd_bank   <= 1'b0;
        end else begin
            // Counter wraps to 0 after the last address of a clear.
            if (w_clr_we) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end else if (r_state == IDLE && clr_req) begin
                r_clr_addr <= '0;
            end
            if (w_swap_fire) begin
                r_front_sel <= ~r_front_sel;
            end
            r_swap_ack <= w_swap_fire;
            // Capture the bank at request time so a read coincident with
            // the swap still returns the old front bank.
            if (rd_en) begin
                r_rd_bank <= r_front_sel;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign swap_ack = r_swap_ack;

    // ------------------------------------------------------------------
    // Memory banks
    // ------------------------------------------------------------------
    logic                 w_we_top;
    logic                 w_we_bot;
    logic [FB_ADDR_W-1:0] w_waddr;
    rgb_t                 w_wdata;
    logic [FB_ADDR_W-1:0] w_raddr;
    rgb_t                 w_top_q [2];
    rgb_t                 w_bot_q [2];

    assign w_we_top = w_clr_we | (w_px_we & ~wr_y[FB_ROW_W-1]);
    assign w_we_bot = w_clr_we | (w_px_we &  wr_y[FB_ROW_W-1]);
    assign w_waddr  = w_clr_we ? r_clr_addr : {wr_y[FB_ROW_W-2:0], wr_x};
    assign w_wdata  = w_clr_we ? CLR_RGB : wr_rgb;
    assign w_raddr  = {rd_row, rd_col};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic c_bank = 1'(b);
        logic w_is_back;
        assign w_is_back = (c_bank != r_front_sel);

        fb_half_ram u_top (
            .clk   (clk),
            .rst   (rst),
            .we    (w_we_top & w_is_back),
            .waddr (w_waddr),
            .wdata (w_wdata),
            .re    (rd_en),
            .raddr (w_raddr),
            .rdata (w_top_q[b])
        );

        fb_half_ram u_bot (
            .clk   (clk),
            .rst   (rst),
            .we    (w_we_bot & w_is_back),
            .waddr (w_waddr),
            .wdata (w_wdata),
            .re    (rd_en),
            .raddr (w_raddr),
            .rdata (w_bot_q[b])
        );
    end

    rgb_t w_bank_rgb0;
    rgb_t w_bank_rgb1;

    assign w_bank_rgb0 = r_rd_bank ? w_top_q[1] : w_top_q[0];
    assign w_bank_rgb1 = r_rd_bank ? w_bot_q[1] : w_bot_q[0];

`ifdef PIXEL_FB_TESTPAT_EN
    rgb_t r_tp_rgb;
    logic r_tp_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tp_rgb <= '0;
            r_tp_sel <= 1'b0;
        end else if (rd_en) begin
            r_tp_rgb <= tp_color(rd_col);
            r_tp_sel <= test_en;
        end
    end

    assign rd_rgb0 = r_tp_sel ? r_tp_rgb : w_bank_rgb0;
    assign rd_rgb1 = r_tp_sel ? r_tp_rgb : w_bank_rgb1;
`else
    logic w_unused_test_en;
    assign w_unused_test_en = test_en;

    assign rd_rgb0 = w_bank_rgb0;
    assign rd_rgb1 = w_bank_rgb1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_frame_buffer
//  Description : Self-checking bench for pixel_frame_buffer: clear/swap flow,
//                table-driven pixel write/read vectors, swap timing corners,
//                reset during clear, and (with PIXEL_FB_TESTPAT_EN) the
//                column test pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pixel_frame_buffer;
    import pixel_fb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic [2:0] wr_rgb;
    logic       clr_req;
    logic       swap_req;
    logic       busy;
    logic       swap_ack;
    logic       rd_en;
    logic [3:0] rd_row;
    logic [5:0] rd_col;
    logic [2:0] rd_rgb0;
    logic [2:0] rd_rgb1;
    logic       frame_done;
    logic       test_en;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pixel_frame_buffer #(.CLR_RGB(3'b000)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_rgb     (wr_rgb),
        .clr_req    (clr_req),
        .swap_req   (swap_req),
        .busy       (busy),
        .swap_ack   (swap_ack),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_rgb0    (rd_rgb0),
        .rd_rgb1    (rd_rgb1),
        .frame_done (frame_done),
        .test_en    (test_en)
    );

    typedef struct {
        logic [5:0] x;
        logic [3:0] row;
        logic [2:0] top;
        logic [2:0] bot;
    } vec_t;

    typedef struct {
        logic [5:0] col;
        logic [2:0] exp_rgb;
    } tp_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input string name);
        int n;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        check(name, n, 1024);
    endtask

    // swap_req then frame_done on the very next cycle: minimum latency path.
    task automatic do_swap(input string name);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check({name, "_busy_wait"}, busy, 1);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check({name, "_ack"}, swap_ack, 1);
        check({name, "_busy_done"}, busy, 0);
        tick();
        check({name, "_ack_clr"}, swap_ack, 0);
    endtask

    task automatic write_px(input logic [5:0] x, input logic [4:0] y, input logic [2:0] c);
        wr_en  = 1'b1;
        wr_x   = x;
        wr_y   = y;
        wr_rgb = c;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [3:0] row, input logic [5:0] col,
                            input logic [2:0] e0, input logic [2:0] e1);
        rd_en  = 1'b1;
        rd_row = row;
        rd_col = col;
        tick();
        rd_en  = 1'b0;
        check({name, "_rgb0"}, rd_rgb0, e0);
        check({name, "_rgb1"}, rd_rgb1, e1);
    endtask

    initial begin
        vec_t vecs [6];
        int   bad;
        int   n;

        vecs[0] = '{x: 6'd0,  row: 4'd0,  top: 3'b001, bot: 3'b110};
        vecs[1] = '{x: 6'd63, row: 4'd0,  top: 3'b010, bot: 3'b101};
        vecs[2] = '{x: 6'd0,  row: 4'd15, top: 3'b111, bot: 3'b011};
        vecs[3] = '{x: 6'd63, row: 4'd15, top: 3'b100, bot: 3'b010};
        vecs[4] = '{x: 6'd31, row: 4'd7,  top: 3'b101, bot: 3'b111};
        vecs[5] = '{x: 6'd32, row: 4'd8,  top: 3'b110, bot: 3'b001};

        rst = 1'b1; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
        clr_req = 1'b0; swap_req = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
        frame_done = 1'b0; test_en = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_rgb0", rd_rgb0, 0);
        check("rst_rgb1", rd_rgb1, 0);
        rst = 1'b0;
        tick();

        // ---------------- clear both banks ----------------
        do_clear("clear1_busy_cycles");          // clears bank 1
        frame_done = 1'b1;                       // no effect in IDLE
        tick();
        frame_done = 1'b0;
        check("idle_fd_busy", busy, 0);
        check("idle_fd_ack", swap_ack, 0);
        do_swap("swap1");                        // front = 1
        do_clear("clear2_busy_cycles");          // clears bank 0

        bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 64; c++) begin
                rd_en = 1'b1; rd_row = 4'(r); rd_col = 6'(c);
                tick();
                rd_en = 1'b0;
                if (rd_rgb0 !== 3'b000 || rd_rgb1 !== 3'b000) bad++;
            end
        end
        check("scan_all_zero_bad_reads", bad, 0);

        // ---------------- write, invisible until swap ----------------
        write_px(6'd5, 5'd3,  3'b011);           // into bank 0 (back)
        write_px(6'd5, 5'd19, 3'b100);
        read_chk("preswap_r3c5", 4'd3, 6'd5, 3'b000, 3'b000);
        do_swap("swap2");                        // front = 0
        read_chk("postswap_r3c5", 4'd3, 6'd5, 3'b011, 3'b100);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 6; i++) begin
            write_px(vecs[i].x, {1'b0, vecs[i].row}, vecs[i].top);
            write_px(vecs[i].x, {1'b1, vecs[i].row}, vecs[i].bot);
        end
        do_swap("swap3");                        // front = 1
        for (int i = 0; i < 6; i++) begin
            read_chk($sformatf("vec%0d", i), vecs[i].row, vecs[i].x, vecs[i].top, vecs[i].bot);
        end
        read_chk("bank1_r3c5", 4'd3, 6'd5, 3'b000, 3'b000);

        // ---------------- long swap wait, requests dropped ----------------
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (i == 100) begin
                wr_en = 1'b1; wr_x = 6'd10; wr_y = 5'd10; wr_rgb = 3'b111;
            end else if (i == 101) begin
                wr_en = 1'b1; wr_x = 6'd5; wr_y = 5'd3; wr_rgb = 3'b110;
            end else if (i == 200) begin
                clr_req = 1'b1;
            end
            tick();
            wr_en = 1'b0;
            clr_req = 1'b0;
            if (busy !== 1'b1 || swap_ack !== 1'b0) bad++;
        end
        check("wait500_bad_cycles", bad, 0);
        read_chk("wait_front_unchanged", 4'd0, 6'd0, 3'b001, 3'b110);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("wait_swap_ack", swap_ack, 1);     // front = 0
        read_chk("dropped_wr_r3c5", 4'd3, 6'd5, 3'b011, 3'b100);
        read_chk("dropped_wr_r10c10", 4'd10, 6'd10, 3'b000, 3'b000);

        // ---------------- swap_req coincident with frame_done ----------------
        swap_req = 1'b1;
        frame_done = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_done = 1'b0;
        check("coinc_busy", busy, 1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (swap_ack !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("coinc_no_early_ack", bad, 0);
        // read issued alongside frame_done sees the old front bank (0)
        frame_done = 1'b1;
        rd_en = 1'b1; rd_row = 4'd3; rd_col = 6'd5;
        tick();
        frame_done = 1'b0;
        rd_en = 1'b0;
        check("coinc_ack", swap_ack, 1);
        check("coinc_read_old_rgb0", rd_rgb0, 3'b011);
        check("coinc_read_old_rgb1", rd_rgb1, 3'b100);
        rd_row = 4'd0; rd_col = 6'd0;
        tick(); tick();
        check("hold_rgb0", rd_rgb0, 3'b011);
        check("hold_rgb1", rd_rgb1, 3'b100);
        read_chk("newfront_r3c5", 4'd3, 6'd5, 3'b000, 3'b000);   // front = 1

        // ---------------- reset mid-clear ----------------
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 298; i++) tick();
        check("midclr_busy", busy, 1);
        read_chk("midclr_read_front1", 4'd15, 6'd63, 3'b100, 3'b010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midclr_rst_busy", busy, 0);
        check("midclr_rst_ack", swap_ack, 0);
        check("midclr_rst_rgb0", rd_rgb0, 0);
        check("midclr_rst_rgb1", rd_rgb1, 0);
        // front is bank 0 again; immediate clr_req is accepted
        clr_req = 1'b1;
        rd_en = 1'b1; rd_row = 4'd15; rd_col = 6'd63;
        tick();
        clr_req = 1'b0;
        rd_en = 1'b0;
        check("reclr_busy", busy, 1);
        check("reclr_front0_rgb0", rd_rgb0, 3'b000);
        check("reclr_front0_rgb1", rd_rgb1, 3'b000);
        n = 1;
        tick();
        while (busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        check("reclr_busy_cycles", n, 1024);

`ifdef PIXEL_FB_TESTPAT_EN
        begin
            tp_vec_t tps [6];
            tps[0] = '{col: 6'd0,  exp_rgb: 3'b100};
            tps[1] = '{col: 6'd2,  exp_rgb: 3'b111};
            tps[2] = '{col: 6'd4,  exp_rgb: 3'b001};
            tps[3] = '{col: 6'd8,  exp_rgb: 3'b010};
            tps[4] = '{col: 6'd16, exp_rgb: 3'b100};
            tps[5] = '{col: 6'd3,  exp_rgb: 3'b000};
            test_en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                read_chk($sformatf("tp%0d", i), 4'd2, tps[i].col, tps[i].exp_rgb, tps[i].exp_rgb);
            end
            test_en = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
